// File: rtl/DMNIPkg.sv
// rtl/DMNIPkg.sv - shared DMNI/NI types for BrLite service messages
//
// Purpose: types and constants shared between the NI and the BrLite
//          service receive path.
// Contents:
//   BRLITE_SVC_FIFO_DEPTH : default entry count of the service receive FIFO
//   brlite_svc_t          : one BrLite service message (72 bits packed)
package DMNIPkg;

   localparam int BRLITE_SVC_FIFO_DEPTH = 8;

   typedef struct packed {
      logic [7:0]  ksvc;
      logic [15:0] producer;
      logic [15:0] seq_source;
      logic [31:0] payload;
   } brlite_svc_t;

endpackage

// File: rtl/brlite_svc_fifo.sv
// rtl/brlite_svc_fifo.sv - receive FIFO for BrLite service messages
//
// Purpose: captures one message per router req/ack handshake into a
//          circular buffer and presents the oldest entry to the NI.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   br_req_i       : router offers br_data_i, held until br_ack_o
//   br_ack_o       : one-cycle capture pulse back to the router
//   br_data_i      : incoming message
//   svc_rx_o       : at least one message stored, svc_data_o valid
//   svc_ack_i      : NI pop pulse, ignored while empty
//   svc_data_o     : head entry (undefined while svc_rx_o is low)
//   occupancy_o    : stored entry count
//   full_o         : occupancy_o == DEPTH
module brlite_svc_fifo
   import DMNIPkg::*;
#(
   parameter int DEPTH = BRLITE_SVC_FIFO_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     br_req_i,
   output logic                     br_ack_o,
   input  brlite_svc_t              br_data_i,
   output logic                     svc_rx_o,
   input  logic                     svc_ack_i,
   output brlite_svc_t              svc_data_o,
   output logic [$clog2(DEPTH):0]   occupancy_o,
   output logic                     full_o
);

   localparam int PtrW = $clog2(DEPTH);
   localparam int CntW = PtrW + 1;

   brlite_svc_t     mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q,  count_d;
   logic            br_ack_q, br_ack_d;
   logic            full;
   logic            push;
   logic            pop;

   always_comb begin
      full = (count_q == CntW'(DEPTH));
      // br_ack_q blocks re-capturing the message the router still holds
      // during the ack cycle. Push looks at the current full flag only, so
      // a same-cycle pop never frees room for a push.
      push = br_req_i && !br_ack_q && !full;
      pop  = svc_ack_i && (count_q != '0);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      br_ack_d = push;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         br_ack_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         br_ack_q <= br_ack_d;
      end
   end

   // Storage is not reset; entries are only meaningful below count_q.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= br_data_i;
      end
   end

   assign svc_data_o  = mem_q[rd_ptr_q];
   assign svc_rx_o    = (count_q != '0);
   assign occupancy_o = count_q;
   assign full_o      = full;
   assign br_ack_o    = br_ack_q;

endmodule

// File: tb/tb_brlite_svc_fifo.sv
// tb/tb_brlite_svc_fifo.sv - self-checking bench for brlite_svc_fifo
module tb_brlite_svc_fifo;
   import DMNIPkg::*;

   localparam int DEPTH = BRLITE_SVC_FIFO_DEPTH;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        br_req_i;
   logic        br_ack_o;
   brlite_svc_t br_data_i;
   logic        svc_rx_o;
   logic        svc_ack_i;
   brlite_svc_t svc_data_o;
   logic [$clog2(DEPTH):0] occupancy_o;
   logic        full_o;

   brlite_svc_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .br_req_i    (br_req_i),
      .br_ack_o    (br_ack_o),
      .br_data_i   (br_data_i),
      .svc_rx_o    (svc_rx_o),
      .svc_ack_i   (svc_ack_i),
      .svc_data_o  (svc_data_o),
      .occupancy_o (occupancy_o),
      .full_o      (full_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a queue of accepted messages plus "router was acked
   // last cycle" flag.
   brlite_svc_t m_q[$];
   bit          m_ack = 1'b0;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("m_rx",   {71'd0, svc_rx_o}, {71'd0, (m_q.size() != 0)});
      chk("m_occ",  72'(occupancy_o), 72'(m_q.size()));
      chk("m_full", {71'd0, full_o}, {71'd0, (m_q.size() == DEPTH)});
      chk("m_ack",  {71'd0, br_ack_o}, {71'd0, m_ack});
      if (m_q.size() != 0) begin
         chk("m_head", svc_data_o, m_q[0]);
      end
   endtask

   // One clock: decide from the inputs presented before the edge what the
   // FIFO must do, then check all outputs 1ns after the edge.
   task automatic tick();
      bit          push;
      bit          pop;
      brlite_svc_t d;
      d    = br_data_i;
      push = rst_ni && br_req_i && !m_ack && (m_q.size() < DEPTH);
      pop  = rst_ni && svc_ack_i && (m_q.size() != 0);
      @(posedge clk_i);
      #1;
      if (rst_ni) begin
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back(d);
         m_ack = push;
      end
      check_model();
   endtask

   function automatic brlite_svc_t mk(input logic [31:0] pl);
      brlite_svc_t m;
      m.ksvc       = 8'($urandom);
      m.producer   = 16'($urandom);
      m.seq_source = 16'($urandom);
      m.payload    = pl;
      return m;
   endfunction

   // Router side: hold req until acked, keep holding through the ack cycle.
   task automatic push_msg(input brlite_svc_t m);
      int n;
      n = 0;
      br_data_i = m;
      br_req_i  = 1'b1;
      do begin
         tick();
         n++;
      end while (!br_ack_o && n < 20);
      chk("push_ack_seen", {71'd0, br_ack_o}, 72'd1);
      tick();
      chk("push_no_dup_ack", {71'd0, br_ack_o}, 72'd0);
      br_req_i = 1'b0;
   endtask

   task automatic pop_one(input logic [31:0] exp_pl);
      chk("pop_rx", {71'd0, svc_rx_o}, 72'd1);
      chk("pop_payload", 72'(svc_data_o.payload), 72'(exp_pl));
      svc_ack_i = 1'b1;
      tick();
      svc_ack_i = 1'b0;
   endtask

   initial begin
      brlite_svc_t m;
      brlite_svc_t held;
      int acks;
      int occ_before;

      rst_ni    = 1'b0;
      br_req_i  = 1'b0;
      svc_ack_i = 1'b0;
      br_data_i = '0;

      // Reset state
      tick();
      tick();
      chk("rst_rx",   {71'd0, svc_rx_o}, 72'd0);
      chk("rst_occ",  72'(occupancy_o), 72'd0);
      chk("rst_full", {71'd0, full_o}, 72'd0);
      chk("rst_ack",  {71'd0, br_ack_o}, 72'd0);
      rst_ni = 1'b1;
      tick();

      // Single push to empty
      m.ksvc = 8'h12; m.producer = 16'h0101; m.seq_source = 16'h0003; m.payload = 32'hDEADBEEF;
      br_data_i = m;
      br_req_i  = 1'b1;
      tick();
      chk("single_ack",  {71'd0, br_ack_o}, 72'd1);
      chk("single_rx",   {71'd0, svc_rx_o}, 72'd1);
      chk("single_occ",  72'(occupancy_o), 72'd1);
      chk("single_head", svc_data_o, {8'h12, 16'h0101, 16'h0003, 32'hDEADBEEF});
      tick();
      chk("single_no_dup_ack", {71'd0, br_ack_o}, 72'd0);
      chk("single_no_dup_occ", 72'(occupancy_o), 72'd1);
      br_req_i = 1'b0;
      tick();
      pop_one(32'hDEADBEEF);
      chk("single_empty", 72'(occupancy_o), 72'd0);

      // Fill to full, then a 9th request held while full
      for (int i = 0; i < DEPTH; i++) push_msg(mk(32'(i)));
      chk("fill_full", {71'd0, full_o}, 72'd1);
      chk("fill_occ", 72'(occupancy_o), 72'(DEPTH));
      br_data_i = mk(32'd8);
      br_req_i  = 1'b1;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (br_ack_o) acks++;
      end
      chk("full_no_ack", 72'(acks), 72'd0);
      chk("full_payload0", 72'(svc_data_o.payload), 72'd0);
      svc_ack_i = 1'b1;
      tick();
      svc_ack_i = 1'b0;
      chk("full_pop_head", 72'(svc_data_o.payload), 72'd1);
      acks = 0;
      for (int i = 0; i < 2; i++) begin
         if (!br_ack_o) begin
            tick();
            if (br_ack_o) acks++;
         end
      end
      chk("ninth_acked", 72'(acks), 72'd1);
      chk("ninth_occ", 72'(occupancy_o), 72'(DEPTH));
      tick();
      br_req_i = 1'b0;
      for (int i = 1; i <= DEPTH; i++) pop_one(32'(i));
      chk("fill_drained", 72'(occupancy_o), 72'd0);

      // Ordering across pointer wrap, occupancy capped at 3
      for (int i = 0; i < 20; i++) begin
         push_msg(mk(32'(100 + i)));
         if (i >= 2) pop_one(32'(100 + i - 2));
         chk("wrap_occ_le3", 72'(occupancy_o <= 3), 72'd1);
      end
      pop_one(32'd118);
      pop_one(32'd119);

      // Simultaneous push and pop at occupancy 2
      push_msg(mk(32'd200));
      push_msg(mk(32'd201));
      br_data_i = mk(32'd202);
      br_req_i  = 1'b1;
      svc_ack_i = 1'b1;
      tick();
      svc_ack_i = 1'b0;
      chk("simul_ack", {71'd0, br_ack_o}, 72'd1);
      chk("simul_occ", 72'(occupancy_o), 72'd2);
      chk("simul_head", 72'(svc_data_o.payload), 72'd201);
      tick();
      br_req_i = 1'b0;
      pop_one(32'd201);
      pop_one(32'd202);

      // Pop on empty
      svc_ack_i = 1'b1;
      tick();
      svc_ack_i = 1'b0;
      chk("empty_pop_occ", 72'(occupancy_o), 72'd0);
      chk("empty_pop_rx", {71'd0, svc_rx_o}, 72'd0);
      push_msg(mk(32'h0000_5A5A));
      pop_one(32'h0000_5A5A);

      // Reset mid-operation with a pending request
      for (int i = 0; i < 3; i++) push_msg(mk(32'(300 + i)));
      held = mk(32'd400);
      br_data_i = held;
      br_req_i  = 1'b1;
      #2;
      rst_ni = 1'b0;
      #1;
      m_q.delete();
      m_ack = 1'b0;
      chk("rstmid_rx",   {71'd0, svc_rx_o}, 72'd0);
      chk("rstmid_occ",  72'(occupancy_o), 72'd0);
      chk("rstmid_full", {71'd0, full_o}, 72'd0);
      chk("rstmid_ack",  {71'd0, br_ack_o}, 72'd0);
      tick();
      tick();
      chk("rstmid_hold_occ", 72'(occupancy_o), 72'd0);
      rst_ni = 1'b1;
      tick();
      chk("rstrel_ack",  {71'd0, br_ack_o}, 72'd1);
      chk("rstrel_occ",  72'(occupancy_o), 72'd1);
      chk("rstrel_head", svc_data_o, held);
      tick();
      chk("rstrel_no_dup", 72'(occupancy_o), 72'd1);
      br_req_i = 1'b0;
      pop_one(32'd400);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         if (br_req_i && br_ack_o) begin
            br_req_i = 1'b0;
         end
         if (!br_req_i && ($urandom_range(0, 3) != 0)) begin
            br_data_i = mk($urandom);
            br_req_i  = 1'b1;
         end
         occ_before = int'(occupancy_o);
         svc_ack_i = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 30 : 70));
         tick();
         chk("rand_occ_bound", 72'(int'(occupancy_o) <= DEPTH), 72'd1);
         if (occ_before == 0) chk("rand_occ_step", 72'(int'(occupancy_o) <= 1), 72'd1);
      end
      br_req_i  = 1'b0;
      svc_ack_i = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) tick();
      svc_ack_i = 1'b0;
      chk("final_empty", 72'(occupancy_o), 72'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/brlite_svc_fifo.md
# brlite_svc_fifo

Receive-side buffer for BrLite service messages, between the BrLite router local output and the NI service-receive MMRs. Accepts one message per router request/acknowledge transaction, stores it in a circular FIFO, and presents the head message to the NI. The NI sees `rx` high while messages are pending and pops with a one-cycle `ack` pulse. Backpressure reaches the router by withholding `ack` while the FIFO is full.

## Interface

Parameters:
- `DEPTH`, default 8: number of entries; must be a power of two, ≥2.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset; asynchronous, active-low.
- `br_req_i`, input, 1: router has a message on `br_data_i`; held until `br_ack_o`.
- `br_ack_o`, output, 1: one-cycle pulse; message captured.
- `br_data_i`, input, `brlite_svc_t`: incoming message (`ksvc`, `producer`, `seq_source`, `payload`).
- `svc_rx_o`, output, 1: FIFO non-empty; head valid.
- `svc_ack_i`, input, 1: NI pop pulse.
- `svc_data_o`, output, `brlite_svc_t`: head entry.
- `occupancy_o`, output, `$clog2(DEPTH)+1`: stored entry count.
- `full_o`, output, 1: `occupancy_o == DEPTH`.

## Operation

- Storage: `DEPTH` × `brlite_svc_t` array, write pointer and read pointer of `$clog2(DEPTH)` bits each, wrap-around by natural overflow.
- A count register of `$clog2(DEPTH)+1` bits tracks occupancy. The count drives `occupancy_o` and `full_o` directly, and `svc_rx_o = (count != 0)`.
- Push condition: `br_req_i && !br_ack_o && !full_o`.
  - On push, write `br_data_i` at the write pointer, increment the write pointer, and set `br_ack_o <= 1` for exactly one cycle.
  - `!br_ack_o` in the condition blocks a second capture of the same message while the router is still holding `br_req_i` in the ack cycle.
- Pop condition: `svc_ack_i && svc_rx_o`. On pop, increment the read pointer. `svc_ack_i` while empty is ignored.
- Count update on simultaneous push and pop: the count is unchanged and both pointers advance.
- Full: push is gated on the current `full_o`. A pop in the same cycle does not enable the push; the push occurs on the next cycle, adding one cycle of ack latency.
- `svc_data_o`: combinational read of the array at the read pointer. It is undefined when empty; consumers must qualify it with `svc_rx_o`.
- Reset values: pointers 0, count 0, `br_ack_o` 0, `svc_rx_o` 0, `occupancy_o` 0, `full_o` 0.
  - Array contents are not reset.
  - Reset mid-transaction discards all entries. A router still holding `br_req_i` after reset release is re-accepted as a new push.

## Timing

- Push latency: `br_ack_o` is high in the cycle after the edge where `br_req_i` is sampled with room available.
- The message is visible on `svc_rx_o`/`svc_data_o` in that same cycle, assuming the FIFO was empty.
- Pop: the next head, or `svc_rx_o` low, appears in the cycle after the edge sampling `svc_ack_i`.
- Throughput:
  - One push every 2 cycles, because the ack pulse blocks the following cycle.
  - One pop per cycle.

## Structure

- `brlite_svc_t` stays in DMNIPkg, shared with the NI. Add `BRLITE_SVC_FIFO_DEPTH` = 8 as the default depth constant there.
- Single module, no sub-modules. Array, pointers, count and ack register all live in one file.

## Test plan

- Single push to empty:
  - Stimulus: hold `br_req_i` with `ksvc=0x12`, `producer=0x0101`, `seq_source=0x0003`, `payload=0xDEADBEEF`.
  - Required: exactly one `br_ack_o` pulse; `svc_rx_o=1`; head matches; `occupancy_o=1`; no duplicate entry while `br_req_i` is still held during the ack cycle.
- Fill to full: 8 pushes with `payload=0..7`, then a 9th request held for 10 cycles.
  - Required: `full_o=1`; no `br_ack_o` for the 9th request.
  - Then one `svc_ack_i` pulse → `payload 0` popped; 9th message acked within 2 cycles; `occupancy_o=8`.
- Ordering and wrap-around: 20 push/pop pairs with `payload=100..119`, interleaved with occupancy never exceeding 3.
  - Required: pops return 100..119 in order across pointer wrap.
- Simultaneous push and pop at `occupancy_o=2`.
  - Required: `occupancy_o` stays 2; head advances to the next older entry.
- Pop on empty: `svc_ack_i` pulse while empty.
  - Required: `occupancy_o` stays 0; `svc_rx_o=0`; next push still returns correct data.
- Reset mid-operation: assert `rst_ni=0` with 3 entries stored and a request pending.
  - Required during reset: all outputs 0.
  - Required after release with request still held: one ack; `occupancy_o=1`; head equals the held message.
